// File: rtl/rob_multi_pkg.sv
// Shared types for the multi-issue reorder buffer: ROB entry record,
// CDB broadcast record and the tag width used inside both records.
// Optional feature macro used by this slice: ROB_BRANCH_FLUSH_EN.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 3
`endif

package rob_multi_pkg;

  localparam int XLEN      = 32;
  // Tag width carried inside the records; must equal $clog2(ROB_SIZE) of the top.
  localparam int ROB_TAG_W = `ROB_TAG_LEN;

  typedef struct packed {
    logic                 valid;
    logic                 ready;
    logic                 wr_mem;
    logic [4:0]           dest_reg;
    logic [XLEN-1:0]      value;
    logic [XLEN-1:0]      store_value;
    logic                 store_ready;
    logic [ROB_TAG_W-1:0] store_dep;
  } rob_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [XLEN-1:0]      value;
  } cdb_data_t;

endpackage

// File: rtl/rob_multi_commit_select.sv
// Combinational head scan: marks the longest run of valid+ready entries
// starting at head, capped at COMMIT_WIDTH, allowing a store only in the
// first retire slot (so at most one store retires per cycle).
module rob_multi_commit_select #(
  parameter int ROB_SIZE     = 8,
  parameter int COMMIT_WIDTH = 2,
  parameter int TAG_LEN      = $clog2(ROB_SIZE)
) (
  input  logic [TAG_LEN-1:0]      head,
  input  logic [ROB_SIZE-1:0]     entry_valid,
  input  logic [ROB_SIZE-1:0]     entry_ready,
  input  logic [ROB_SIZE-1:0]     entry_store,
  output logic [COMMIT_WIDTH-1:0] commit_valid,
  output logic [TAG_LEN:0]        commit_count
);

  logic               scan_on;
  logic [TAG_LEN-1:0] idx;

  // Scan oldest-first; the first entry that cannot retire ends the run.
  always_comb begin
    commit_valid = '0;
    commit_count = '0;
    scan_on      = 1'b1;
    idx          = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      idx = head + TAG_LEN'(k);
      if (scan_on && entry_valid[idx] && entry_ready[idx] &&
          (!entry_store[idx] || k == 0)) begin
        commit_valid[k] = 1'b1;
        commit_count    = commit_count + 1'b1;
      end else begin
        scan_on = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi.sv
// Multi-issue reorder buffer: ALLOC_WIDTH dispatch slots, CDB_PORTS result
// buses, COMMIT_WIDTH in-order retire slots, operand read with CDB bypass
// and an older-store query for loads.
// Optional feature macro: ROB_BRANCH_FLUSH_EN (adds flush_valid/flush_tag).
import rob_multi_pkg::*;

module rob_multi #(
  parameter int ROB_SIZE     = 8,
  parameter int ALLOC_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int CDB_PORTS    = 2,
  parameter int TAG_LEN      = $clog2(ROB_SIZE)
) (
  input  logic                                clock,
  input  logic                                reset,
`ifdef ROB_BRANCH_FLUSH_EN
  input  logic                                flush_valid,
  input  logic [TAG_LEN-1:0]                  flush_tag,
`endif
  input  logic [ALLOC_WIDTH-1:0]              alloc_enable,
  input  logic [ALLOC_WIDTH-1:0]              alloc_wr_mem,
  input  logic [ALLOC_WIDTH-1:0][4:0]         alloc_dest_reg,
  input  logic [ALLOC_WIDTH-1:0]              alloc_value_ready,
  input  logic [ALLOC_WIDTH-1:0][XLEN-1:0]    alloc_store_value,
  input  logic [ALLOC_WIDTH-1:0][TAG_LEN-1:0] alloc_store_dep,
  input  cdb_data_t [CDB_PORTS-1:0]           cdb_data,
  input  logic [TAG_LEN-1:0]                  read_rob_tag,
  input  logic [TAG_LEN-1:0]                  load_rob_tag,
  output logic                                full,
  output logic [ALLOC_WIDTH-1:0][TAG_LEN-1:0] alloc_slot,
  output logic [XLEN-1:0]                     read_value,
  output logic                                pending_stores,
  output logic [COMMIT_WIDTH-1:0]             commit_valid,
  output rob_entry_t [COMMIT_WIDTH-1:0]       commit_entry
);

  rob_entry_t               rob_q [ROB_SIZE];
  logic [TAG_LEN-1:0]       head;
  logic [TAG_LEN-1:0]       tail;
  logic [TAG_LEN:0]         count;

  logic [TAG_LEN:0]         alloc_count;
  logic [TAG_LEN:0]         commit_count;
  logic                     do_alloc;
  rob_entry_t               new_entry [ALLOC_WIDTH];
  logic [TAG_LEN-1:0]       entry_off [ROB_SIZE];
  logic [TAG_LEN-1:0]       load_off;
  logic [ROB_SIZE-1:0]      live_valid;
  logic [ROB_SIZE-1:0]      entry_ready;
  logic [ROB_SIZE-1:0]      entry_store;
`ifdef ROB_BRANCH_FLUSH_EN
  logic [TAG_LEN-1:0]       flush_off;
  logic [ROB_SIZE-1:0]      squash;
`endif

  // Free-space check uses only the registered count; retiring entries give no credit.
  assign full = ((TAG_LEN+1)'(ROB_SIZE) - count) < (TAG_LEN+1)'(ALLOC_WIDTH);

  // Age bookkeeping: offsets from head, live entries (flush-masked) and per-slot tags.
  always_comb begin
    load_off = load_rob_tag - head;
`ifdef ROB_BRANCH_FLUSH_EN
    flush_off = flush_tag - head;
    squash    = '0;
`endif
    for (int j = 0; j < ROB_SIZE; j++) begin
      entry_off[j]   = TAG_LEN'(j) - head;
      entry_ready[j] = rob_q[j].ready;
      entry_store[j] = rob_q[j].wr_mem;
`ifdef ROB_BRANCH_FLUSH_EN
      squash[j]      = flush_valid && rob_q[j].valid && (entry_off[j] > flush_off);
      live_valid[j]  = rob_q[j].valid && !squash[j];
`else
      live_valid[j]  = rob_q[j].valid;
`endif
    end
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_slot[i] = tail + TAG_LEN'(i);
    end
  end

  // Build the entries written at dispatch, including a same-cycle CDB store-value catch.
  always_comb begin
    alloc_count = '0;
`ifdef ROB_BRANCH_FLUSH_EN
    do_alloc = !full && !flush_valid;
`else
    do_alloc = !full;
`endif
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_count              = alloc_count + (TAG_LEN+1)'(alloc_enable[i]);
      new_entry[i]             = '0;
      new_entry[i].valid       = 1'b1;
      new_entry[i].wr_mem      = alloc_wr_mem[i];
      new_entry[i].dest_reg    = alloc_dest_reg[i];
      new_entry[i].store_value = alloc_store_value[i];
      new_entry[i].store_ready = alloc_value_ready[i];
      new_entry[i].store_dep   = alloc_store_dep[i];
      // Descending scan so the lowest-index matching port wins.
      for (int p = CDB_PORTS-1; p >= 0; p--) begin
        if (!alloc_value_ready[i] && cdb_data[p].valid &&
            cdb_data[p].rob_tag == alloc_store_dep[i]) begin
          new_entry[i].store_value = cdb_data[p].value;
          new_entry[i].store_ready = 1'b1;
        end
      end
    end
  end

  // Operand read with CDB bypass (lowest port wins) and the older-store query.
  always_comb begin
    read_value     = rob_q[read_rob_tag].value;
    pending_stores = 1'b0;
    for (int p = CDB_PORTS-1; p >= 0; p--) begin
      if (cdb_data[p].valid && cdb_data[p].rob_tag == read_rob_tag) begin
        read_value = cdb_data[p].value;
      end
    end
    // Head itself counts as older than the load; the load's own slot does not.
    for (int j = 0; j < ROB_SIZE; j++) begin
      if (rob_q[j].valid && rob_q[j].wr_mem && (entry_off[j] < load_off)) begin
        pending_stores = 1'b1;
      end
    end
  end

  rob_multi_commit_select #(
    .ROB_SIZE     (ROB_SIZE),
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .TAG_LEN      (TAG_LEN)
  ) u_commit_select (
    .head         (head),
    .entry_valid  (live_valid),
    .entry_ready  (entry_ready),
    .entry_store  (entry_store),
    .commit_valid (commit_valid),
    .commit_count (commit_count)
  );

  // Retiring entries presented oldest-first.
  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      commit_entry[k] = rob_q[head + TAG_LEN'(k)];
    end
  end

  // Entry array and pointer update: retire, CDB capture, squash, allocate.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int j = 0; j < ROB_SIZE; j++) begin
        rob_q[j] <= '0;
      end
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (commit_valid[k]) begin
          rob_q[head + TAG_LEN'(k)].valid <= 1'b0;
        end
      end
      for (int j = 0; j < ROB_SIZE; j++) begin
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (cdb_data[p].valid && rob_q[j].valid && cdb_data[p].rob_tag == TAG_LEN'(j)) begin
            rob_q[j].ready <= 1'b1;
            rob_q[j].value <= cdb_data[p].value;
          end
          if (cdb_data[p].valid && rob_q[j].valid && rob_q[j].wr_mem &&
              !rob_q[j].store_ready && cdb_data[p].rob_tag == rob_q[j].store_dep) begin
            rob_q[j].store_value <= cdb_data[p].value;
            rob_q[j].store_ready <= 1'b1;
          end
        end
`ifdef ROB_BRANCH_FLUSH_EN
        if (squash[j]) begin
          rob_q[j].valid <= 1'b0;
        end
`endif
      end
      // Dispatch targets only free slots, so it never collides with the writes above.
      if (do_alloc) begin
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
          if (alloc_enable[i]) begin
            rob_q[tail + TAG_LEN'(i)] <= new_entry[i];
          end
        end
      end
      head <= head + commit_count[TAG_LEN-1:0];
`ifdef ROB_BRANCH_FLUSH_EN
      if (flush_valid) begin
        tail  <= flush_tag + 1'b1;
        count <= {1'b0, flush_off} + 1'b1 - commit_count;
      end else if (do_alloc) begin
        tail  <= tail + alloc_count[TAG_LEN-1:0];
        count <= count + alloc_count - commit_count;
      end else begin
        count <= count - commit_count;
      end
`else
      if (do_alloc) begin
        tail  <= tail + alloc_count[TAG_LEN-1:0];
        count <= count + alloc_count - commit_count;
      end else begin
        count <= count - commit_count;
      end
`endif
    end
  end

  // Two CDB ports must never broadcast the same tag in one cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int p = 0; p < CDB_PORTS; p++) begin
        for (int q = p + 1; q < CDB_PORTS; q++) begin
          assert (!(cdb_data[p].valid && cdb_data[q].valid &&
                    cdb_data[p].rob_tag == cdb_data[q].rob_tag));
        end
      end
    end
  end

endmodule
